// File: rtl/frame_bin_avg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : frame_bin_avg_pkg
// Description : Shared types and width helpers for the frame bin averager.
// Revision    : 1.0 - initial release
// ============================================================================
package frame_bin_avg_pkg;

  typedef enum logic [0:0] {
    WAIT_SOP = 1'b0,
    ACCUM    = 1'b1
  } state_t;

  function automatic int k_width(input int max_avgs_log2);
    return (max_avgs_log2 < 1) ? 1 : $clog2(max_avgs_log2 + 1);
  endfunction

  function automatic int frame_width(input int max_avgs_log2);
    return (max_avgs_log2 < 1) ? 1 : max_avgs_log2;
  endfunction

  // Growth of 2^MAX frames of N-bit samples needs MAX extra bits.
  function automatic int sum_width_default(input int n, input int max_avgs_log2);
    return n + max_avgs_log2;
  endfunction

  function automatic int unsigned clamp_k(input int unsigned n, input int unsigned max_k);
    return (n > max_k) ? max_k : n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/frame_bin_avg_if.sv
`default_nettype none
// ============================================================================
// Module      : frame_bin_avg_if
// Description : FFT-beat input stream and averaged-frame output stream bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface frame_bin_avg_if #(
  parameter int N             = 16,
  parameter int BINS          = 4,
  parameter int MAX_AVGS_LOG2 = 7
);
  import frame_bin_avg_pkg::*;

  localparam int KW = k_width(MAX_AVGS_LOG2);

  logic [KW-1:0]            n_avgs_log2;
  logic                     fft_valid;
  logic                     fft_sop;
  logic [BINS-1:0][N-1:0]   in_data;
  logic                     out_valid;
  logic                     out_sop;
  logic [BINS-1:0][N-1:0]   out_data;
  logic                     frame_err;

  modport master (
    output n_avgs_log2, fft_valid, fft_sop, in_data,
    input  out_valid, out_sop, out_data, frame_err
  );

  modport slave (
    input  n_avgs_log2, fft_valid, fft_sop, in_data,
    output out_valid, out_sop, out_data, frame_err
  );

endinterface
`default_nettype wire

// File: rtl/frame_bin_avg_bin_acc_ram.sv
`default_nettype none
// ============================================================================
// Module      : bin_acc_ram
// Description : Simple dual-port accumulator RAM with 1-cycle registered read.
// Revision    : 1.0 - initial release
// ============================================================================
module bin_acc_ram #(
  parameter  int DEPTH = 256,
  parameter  int WIDTH = 92,
  localparam int AW    = $clog2(DEPTH)
) (
  input  wire logic             clk,
  input  wire logic             wr_en,
  input  wire logic [AW-1:0]    wr_addr,
  input  wire logic [WIDTH-1:0] wr_data,
  input  wire logic             rd_en,
  input  wire logic [AW-1:0]    rd_addr,
  output logic      [WIDTH-1:0] rd_data
);

  // Storage is never reset: frame 0 of every set overwrites each word.
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= r_mem[rd_addr];
  end

endmodule
`default_nettype wire

// File: rtl/frame_bin_avg.sv
`default_nettype none
// ============================================================================
// Module      : frame_bin_avg
// Description : Averages 2^k consecutive FFT frames bin-by-bin, 2-cycle latency.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_bin_avg
  import frame_bin_avg_pkg::*;
#(
  parameter int N             = 16,
  parameter int BINS          = 4,
  parameter int FRAME_BEATS   = 256,
  parameter int MAX_AVGS_LOG2 = 7,
  parameter int SUM_WIDTH     = sum_width_default(N, MAX_AVGS_LOG2)
) (
  input wire logic       clk,
  input wire logic       rst_n,
  frame_bin_avg_if.slave bus
);

  localparam int KW     = k_width(MAX_AVGS_LOG2);
  localparam int FW     = frame_width(MAX_AVGS_LOG2);
  localparam int BW     = $clog2(FRAME_BEATS);
  localparam int WORD_W = BINS * SUM_WIDTH;
  localparam logic [BW-1:0] LAST_BEAT = BW'(FRAME_BEATS - 1);

  if (FRAME_BEATS < 4) begin : g_chk_beats
    $error("frame_bin_avg: FRAME_BEATS must be at least 4");
  end
  if (SUM_WIDTH < N + MAX_AVGS_LOG2) begin : g_chk_sum
    $error("frame_bin_avg: SUM_WIDTH too small for N + MAX_AVGS_LOG2");
  end

  state_t                 r_state, w_state_nxt;
  logic [BW-1:0]          r_beat, w_beat_nxt, w_addr;
  logic [FW-1:0]          r_frame, w_frame_nxt, w_last_frame;
  logic [KW-1:0]          r_k, w_k_nxt, w_k_in, w_k_cur;
  logic                   w_take, w_first, w_last, w_start, w_err;

  logic                   r_s1_valid, r_s1_first, r_s1_last, r_s1_sop, r_err;
  logic [KW-1:0]          r_s1_k;
  logic [BW-1:0]          r_s1_addr;
  logic [BINS-1:0][N-1:0] r_s1_data;

  logic [BINS-1:0][SUM_WIDTH-1:0] w_rd_word, w_sum;
  logic [BINS-1:0][N-1:0]         w_avg;
  logic                           w_wr_en;

  logic                   r_out_valid, r_out_sop;
  logic [BINS-1:0][N-1:0] r_out_data;

  assign w_k_in       = KW'(clamp_k(32'(bus.n_avgs_log2), MAX_AVGS_LOG2));
  assign w_last_frame = FW'((32'd1 << r_k) - 32'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= WAIT_SOP;
      r_beat  <= '0;
      r_frame <= '0;
      r_k     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_beat  <= w_beat_nxt;
      r_frame <= w_frame_nxt;
      r_k     <= w_k_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_frame_nxt = r_frame;
    w_k_nxt     = r_k;
    w_k_cur     = r_k;
    w_addr      = r_beat;
    w_take      = 1'b0;
    w_first     = 1'b0;
    w_last      = 1'b0;
    w_start     = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      WAIT_SOP: begin
        if (bus.fft_valid && bus.fft_sop) w_start = 1'b1;
      end
      ACCUM: begin
        if (bus.fft_valid) begin
          if (bus.fft_sop && (r_beat != '0)) begin
            // Early sop: abandon the partial set and restart on this beat.
            w_err   = 1'b1;
            w_start = 1'b1;
          end else if (!bus.fft_sop && (r_beat == '0)) begin
            w_err       = 1'b1;
            w_state_nxt = WAIT_SOP;
            w_frame_nxt = '0;
          end else begin
            w_take  = 1'b1;
            w_first = (r_frame == '0);
            w_last  = (r_frame == w_last_frame);
            if (r_beat == LAST_BEAT) begin
              w_beat_nxt = '0;
              if (w_last) begin
                w_frame_nxt = '0;
                w_k_nxt     = w_k_in;
              end else begin
                w_frame_nxt = r_frame + FW'(1);
              end
            end else begin
              w_beat_nxt = r_beat + BW'(1);
            end
          end
        end
      end
      default: w_state_nxt = WAIT_SOP;
    endcase
    if (w_start) begin
      w_take      = 1'b1;
      w_first     = 1'b1;
      w_k_cur     = w_k_in;
      w_last      = (w_k_in == '0);
      w_addr      = '0;
      w_k_nxt     = w_k_in;
      w_beat_nxt  = BW'(1);
      w_frame_nxt = '0;
      w_state_nxt = ACCUM;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_sop   <= 1'b0;
      r_s1_k     <= '0;
      r_s1_addr  <= '0;
      r_s1_data  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_s1_valid <= w_take;
      r_s1_first <= w_first;
      r_s1_last  <= w_last;
      r_s1_sop   <= w_take && w_last && (w_addr == '0);
      r_s1_k     <= w_k_cur;
      r_s1_addr  <= w_addr;
      r_s1_data  <= bus.in_data;
      r_err      <= w_err;
    end
  end

  bin_acc_ram #(
    .DEPTH (FRAME_BEATS),
    .WIDTH (WORD_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (w_wr_en),
    .wr_addr (r_s1_addr),
    .wr_data (w_sum),
    .rd_en   (w_take),
    .rd_addr (w_addr),
    .rd_data (w_rd_word)
  );

  // The final frame only feeds the output; its sum is never stored.
  assign w_wr_en = r_s1_valid && !r_s1_last;

  for (genvar i = 0; i < BINS; i++) begin : g_lane
    assign w_sum[i] = (r_s1_first ? '0 : w_rd_word[i]) + SUM_WIDTH'(r_s1_data[i]);
    assign w_avg[i] = N'(w_sum[i] >> r_s1_k);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_sop   <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_out_valid <= r_s1_valid && r_s1_last;
      r_out_sop   <= r_s1_valid && r_s1_sop;
      if (r_s1_valid && r_s1_last) r_out_data <= w_avg;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_sop   = r_out_sop;
  assign bus.out_data  = r_out_data;
  assign bus.frame_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_frame_bin_avg.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_bin_avg
// Description : Directed self-checking bench for frame_bin_avg (BINS=4, 8 beats).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_bin_avg;

  localparam int N    = 16;
  localparam int BINS = 4;
  localparam int FB   = 8;
  localparam int MAXL = 7;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  frame_bin_avg_if #(.N(N), .BINS(BINS), .MAX_AVGS_LOG2(MAXL)) bus ();

  frame_bin_avg #(
    .N             (N),
    .BINS          (BINS),
    .FRAME_BEATS   (FB),
    .MAX_AVGS_LOG2 (MAXL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests   = 0;
  int fails   = 0;
  int cyc     = 0;
  int err_cnt = 0;
  bit rec_in  = 1'b0;
  logic [63:0] out_q[$];
  bit          sop_q[$];
  int          ocyc_q[$];
  int          icyc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      out_q.push_back(bus.out_data);
      sop_q.push_back(bus.out_sop);
      ocyc_q.push_back(cyc);
    end
    if (bus.frame_err === 1'b1) err_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Lane l of beat b carries base (+ 3*l + b when ramp is set).
  function automatic logic [63:0] word(input logic [15:0] base, input int b, input bit ramp);
    logic [63:0] w;
    for (int l = 0; l < BINS; l++)
      w[l*16 +: 16] = base + (ramp ? 16'(l * 3 + b) : 16'd0);
    return w;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.fft_valid = 1'b0;
      bus.fft_sop   = 1'b0;
    end
  endtask

  task automatic send_beat(input bit sop, input logic [15:0] base, input int b, input bit ramp);
    @(negedge clk);
    bus.fft_valid = 1'b1;
    bus.fft_sop   = sop;
    bus.in_data   = word(base, b, ramp);
    if (rec_in) icyc_q.push_back(cyc);
  endtask

  task automatic send_frame(input logic [15:0] base, input bit ramp, input int gap_max = 0,
                            input int nbeats = FB, input int sop_beat = 0);
    for (int b = 0; b < nbeats; b++) begin
      send_beat(b == sop_beat, base, b, ramp);
      if (gap_max > 0) idle($urandom_range(gap_max, 0));
    end
  endtask

  task automatic clear_logs();
    out_q.delete();
    sop_q.delete();
    ocyc_q.delete();
    icyc_q.delete();
    err_cnt = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n         = 1'b0;
    bus.fft_valid = 1'b0;
    bus.fft_sop   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic check_set(input string tag, input int nb, input logic [15:0] base, input bit ramp);
    chk({tag, " count"}, 64'(out_q.size()), 64'(nb));
    for (int j = 0; j < out_q.size() && j < nb; j++) begin
      chk($sformatf("%s data[%0d]", tag, j), out_q[j], word(base, j % FB, ramp));
      chk($sformatf("%s sop[%0d]", tag, j), 64'(sop_q[j]), 64'(j % FB == 0));
    end
    out_q.delete();
    sop_q.delete();
    ocyc_q.delete();
  endtask

  initial begin
    bus.fft_valid   = 1'b0;
    bus.fft_sop     = 1'b0;
    bus.in_data     = '0;
    bus.n_avgs_log2 = '0;
    repeat (3) @(negedge clk);
    chk("reset out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset out_sop",   64'(bus.out_sop),   64'd0);
    chk("reset frame_err", 64'(bus.frame_err), 64'd0);
    chk("reset out_data",  bus.out_data,       64'd0);
    rst_n = 1'b1;

    // k=2, constant 100: nothing during first three frames, then 8 beats of 100.
    do_reset();
    bus.n_avgs_log2 = 3'd2;
    repeat (3) send_frame(16'd100, 1'b0);
    idle(4);
    chk("k2 const early", 64'(out_q.size()), 64'd0);
    send_frame(16'd100, 1'b0);
    idle(4);
    check_set("k2 const", 8, 16'd100, 1'b0);
    chk("k2 const err", 64'(err_cnt), 64'd0);

    // k=3, frame f carries 8f: sum 224, >>3 = 28.
    do_reset();
    bus.n_avgs_log2 = 3'd3;
    for (int f = 0; f < 8; f++) send_frame(16'(8 * f), 1'b0);
    idle(4);
    check_set("k3 ramp", 8, 16'd28, 1'b0);

    // k=3, full-scale input must come back unchanged.
    do_reset();
    for (int f = 0; f < 8; f++) send_frame(16'hFFFF, 1'b0);
    idle(4);
    check_set("k3 full", 8, 16'hFFFF, 1'b0);

    // k=2 with random gaps: bases 10+20+30+41 = 101, (101+4*off)>>2 = 25+off.
    do_reset();
    bus.n_avgs_log2 = 3'd2;
    send_frame(16'd10, 1'b1, 5);
    send_frame(16'd20, 1'b1, 5);
    send_frame(16'd30, 1'b1, 5);
    rec_in = 1'b1;
    send_frame(16'd41, 1'b1, 5);
    rec_in = 1'b0;
    idle(6);
    chk("gap count", 64'(ocyc_q.size()), 64'(icyc_q.size()));
    for (int j = 0; j < ocyc_q.size() && j < icyc_q.size(); j++)
      chk($sformatf("gap lat[%0d]", j), 64'(ocyc_q[j]), 64'(icyc_q[j] + 2));
    check_set("gap data", 8, 16'd25, 1'b1);

    // Missing sop on beat 0 of frame 1: one error pulse, no output.
    do_reset();
    bus.n_avgs_log2 = 3'd2;
    send_frame(16'd500, 1'b0);
    send_frame(16'd500, 1'b0, 0, FB, -1);
    idle(4);
    chk("nosop err", 64'(err_cnt), 64'd1);
    chk("nosop out", 64'(out_q.size()), 64'd0);

    // sop at beat 3 of frame 1: restart, output only after four fresh frames.
    do_reset();
    bus.n_avgs_log2 = 3'd2;
    send_frame(16'd500, 1'b0);
    send_frame(16'd500, 1'b0, 0, 3);
    repeat (3) send_frame(16'd40, 1'b0);
    idle(4);
    chk("early sop err", 64'(err_cnt), 64'd1);
    chk("early sop out", 64'(out_q.size()), 64'd0);
    send_frame(16'd40, 1'b0);
    idle(4);
    check_set("early sop set", 8, 16'd40, 1'b0);

    // n changes 2->0 mid-set: set of 4+8+12+16 -> 10+off, then pass-through.
    do_reset();
    bus.n_avgs_log2 = 3'd2;
    send_frame(16'd4, 1'b1);
    send_frame(16'd8, 1'b1);
    idle(1);
    bus.n_avgs_log2 = 3'd0;
    send_frame(16'd12, 1'b1);
    idle(4);
    chk("kchg early", 64'(out_q.size()), 64'd0);
    send_frame(16'd16, 1'b1);
    idle(4);
    check_set("kchg set", 8, 16'd10, 1'b1);
    send_frame(16'd77, 1'b1);
    idle(4);
    check_set("pass0", 8, 16'd77, 1'b1);
    bus.n_avgs_log2 = 3'd2;
    send_frame(16'd90, 1'b1);
    idle(4);
    check_set("pass1", 8, 16'd90, 1'b1);

    // Reset during frame 2 of a k=2 set: outputs clear at once, set discarded.
    send_frame(16'd200, 1'b0);
    send_frame(16'd200, 1'b0);
    send_frame(16'd200, 1'b0, 0, 4);
    @(negedge clk);
    bus.fft_valid = 1'b0;
    bus.fft_sop   = 1'b0;
    rst_n         = 1'b0;
    #1;
    chk("midrst out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst out_sop",   64'(bus.out_sop),   64'd0);
    chk("midrst frame_err", 64'(bus.frame_err), 64'd0);
    chk("midrst out_data",  bus.out_data,       64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    for (int b = 4; b < FB; b++) send_beat(1'b0, 16'd200, b, 1'b0);
    repeat (3) send_frame(16'd60, 1'b0);
    idle(4);
    chk("postrst early", 64'(out_q.size()), 64'd0);
    chk("postrst err", 64'(err_cnt), 64'd0);
    send_frame(16'd60, 1'b0);
    idle(4);
    check_set("postrst set", 8, 16'd60, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/frame_bin_avg.md
FRAME_BIN_AVG -- requirements
Module: frame_bin_avg

Interface
REQ-001 Parameter N, default 16: unsigned input sample width per bin.
REQ-002 Parameter BINS, default 4: bins delivered in parallel per beat (lanes).
REQ-003 Parameter FRAME_BEATS, default 256: beats per FFT frame; frame = BINS*FRAME_BEATS bins.
REQ-004 Parameter MAX_AVGS_LOG2, default 7: largest log2 average count supported.
REQ-005 Parameter SUM_WIDTH, default N+MAX_AVGS_LOG2: accumulator width per bin.
REQ-006 clk  in  1  single clock; all logic rising-edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 n_avgs_log2  in  $clog2(MAX_AVGS_LOG2+1)  log2 of frames to average; values above MAX_AVGS_LOG2 clamp to MAX_AVGS_LOG2.
REQ-009 fft_valid  in  1  in_data beat valid; no backpressure.
REQ-010 fft_sop  in  1  first beat of a frame; qualified by fft_valid.
REQ-011 in_data  in  BINS x N  one beat of bins.
REQ-012 out_valid  out  1  out_data beat valid.
REQ-013 out_sop  out  1  first beat of an averaged frame.
REQ-014 out_data  out  BINS x N  averaged bins.
REQ-015 frame_err  out  1  one-cycle pulse on frame-length violation.

Function
REQ-016 States: WAIT_SOP, ACCUM; beat counter 0..FRAME_BEATS-1, frame counter 0..2^k-1 (k = latched n_avgs_log2).
REQ-017 WAIT_SOP: beats ignored until fft_valid&&fft_sop; that beat enters ACCUM as beat 0, frame 0; k latched on this beat.
REQ-018 Frame 0 writes in_data (zero-extended to SUM_WIDTH) into accumulator RAM, overwriting old contents; frames 1..2^k-1 write RAM+in_data.
REQ-019 Beat counter advances only on fft_valid; gaps of any length inside a frame are legal.
REQ-020 Last beat of a frame: beat counter wraps to 0, frame counter increments; after frame 2^k-1 it wraps to 0 and k is re-latched from n_avgs_log2.
REQ-021 During final frame (2^k-1), out_data lane i = (RAM_i + in_data_i) >> k, truncated to N bits; out_valid asserted per valid beat; no RAM write needed.
REQ-022 k = 0: every frame passes straight through, out_data = in_data.
REQ-023 Latency fft_valid to out_valid exactly 2 cycles, fixed, gaps preserved; out_sop on beat 0 of final frame.
REQ-024 fft_sop on beat other than beat 0: pulse frame_err, discard partial set, treat beat as beat 0 frame 0.
REQ-025 Missing fft_sop on beat 0 of frame >0: pulse frame_err, go WAIT_SOP, no output for that set.
REQ-026 Read-modify-write hazard impossible (same address revisited only after FRAME_BEATS beats); FRAME_BEATS >= 4 required, checked by elaboration assertion.
REQ-027 Sum cannot overflow: SUM_WIDTH >= N+MAX_AVGS_LOG2, checked by elaboration assertion.

Reset
REQ-028 rst_n low: state WAIT_SOP, counters 0, k 0, out_valid/out_sop/frame_err 0, out_data 0, pipeline valids 0.
REQ-029 RAM contents not reset; first frame overwrite makes them irrelevant.
REQ-030 Reset mid-set discards it; first output after release only after a full 2^k-frame set beginning with fft_sop.

Structure
REQ-031 Package frame_bin_avg_pkg: state enum, width helper functions, SUM_WIDTH default rule.
REQ-032 Sub-module bin_acc_ram: simple dual-port RAM, depth FRAME_BEATS, width BINS*SUM_WIDTH, 1-cycle registered read.
REQ-033 Read address issued on input beat; add and shift in stage 2; outputs registered.

Verification
REQ-034 BINS=4, FRAME_BEATS=8, k=2, constant in_data 100 per bin, 4 frames -> 8 out beats each 100, out_sop on first, none before.
REQ-035 k=3, bin values frame f = 8f (f=0..7) -> out_data 28 every bin; values 0xFFFF all frames -> 0xFFFF, no overflow.
REQ-036 Random 0-5 cycle fft_valid gaps -> out_valid pattern equals input pattern delayed 2 cycles, results match model.
REQ-037 fft_sop at beat 3 of frame 1 -> frame_err one cycle, set restarts, next output after 2^k full frames.
REQ-038 n_avgs_log2 changed 2->0 mid-set -> current set completes with k=2, then pass-through frames.
REQ-039 rst_n pulsed low during frame 2 -> all outputs 0 immediately, no output until new complete set.
